mcpu_ram_arbiter: RTL and testbench

- Shares the single data port of the MCPU RAM controller between two requesters.
- Port 0 is the MCPU WB-stage data access. Port 1 is a DMA/debug loader.
- Arbitration is round-robin, with an optional lock for burst ownership.
- The RAM command is registered. Read data returns with a fixed 2-cycle latency after grant, tagged to the owning port.

---
 rtl/mcpu_ram_arbiter.sv | 128 ++++++++++++
 tb/tb_mcpu_ram_arbiter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mcpu_ram_arbiter.sv
// Two-port round-robin arbiter in front of the MCPU RAM data port, with optional
// per-port lock for burst ownership, a registered RAM command and a 2-cycle tagged read return.
module mcpu_ram_arbiter #(
  parameter int WORD_SIZE  = 16,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0,
  input  logic                  we0,
  input  logic                  lock0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [WORD_SIZE-1:0]  wdata0,
  output logic                  gnt0,
  output logic                  rvalid0,
  input  logic                  req1,
  input  logic                  we1,
  input  logic                  lock1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [WORD_SIZE-1:0]  wdata1,
  output logic                  gnt1,
  output logic                  rvalid1,
  output logic [WORD_SIZE-1:0]  rdata,
  output logic                  ram_we,
  output logic                  ram_re,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [WORD_SIZE-1:0]  ram_wdata,
  input  logic [WORD_SIZE-1:0]  ram_rdata
);

  typedef enum logic [1:0] {
    ARB  = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t state, state_next;
  logic   last_gnt, last_gnt_next;

  logic                  gnt_any;
  logic                  sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [WORD_SIZE-1:0]  sel_wdata;

  logic tag1_valid, tag1_port;
  logic tag2_valid, tag2_port;

  // Handshake: reqN/weN/lockN/addrN/wdataN are held stable by the requester until
  // gntN is seen high; the access is accepted at that rising edge, and a new access
  // may be presented in the very next cycle. gntN is combinational from the reqs.
  always_comb begin
    gnt0          = 1'b0;
    gnt1          = 1'b0;
    state_next    = state;
    last_gnt_next = last_gnt;
    if (!reset) begin
      if (state == OWN0 && req0) begin
        gnt0 = 1'b1;
      end else if (state == OWN1 && req1) begin
        gnt1 = 1'b1;
      end else if (req0 && req1) begin
        // Conflict goes to the port that did not win last time.
        gnt0 = last_gnt;
        gnt1 = ~last_gnt;
      end else begin
        // An owner that dropped its req falls back to plain arbitration this cycle.
        gnt0 = req0;
        gnt1 = req1;
      end

      if (gnt0) begin
        state_next    = lock0 ? OWN0 : ARB;
        last_gnt_next = 1'b0;
      end else if (gnt1) begin
        state_next    = lock1 ? OWN1 : ARB;
        last_gnt_next = 1'b1;
      end else begin
        state_next = ARB;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ARB;
      last_gnt <= 1'b1;
    end else begin
      state    <= state_next;
      last_gnt <= last_gnt_next;
    end
  end

  assign gnt_any   = gnt0 | gnt1;
  assign sel_we    = gnt1 ? we1    : we0;
  assign sel_addr  = gnt1 ? addr1  : addr0;
  assign sel_wdata = gnt1 ? wdata1 : wdata0;

  // Command register plus the owner tag that travels with each read.
  always_ff @(posedge clk) begin
    if (reset) begin
      ram_we     <= 1'b0;
      ram_re     <= 1'b0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
      tag1_valid <= 1'b0;
      tag1_port  <= 1'b0;
      tag2_valid <= 1'b0;
      tag2_port  <= 1'b0;
      rdata      <= '0;
    end else begin
      ram_we     <= gnt_any & sel_we;
      ram_re     <= gnt_any & ~sel_we;
      if (gnt_any) begin
        ram_addr  <= sel_addr;
        ram_wdata <= sel_wdata;
      end
      tag1_valid <= gnt_any & ~sel_we;
      tag1_port  <= gnt1;
      tag2_valid <= tag1_valid;
      tag2_port  <= tag1_port;
      if (tag1_valid) rdata <= ram_rdata;
    end
  end

  assign rvalid0 = tag2_valid & ~tag2_port;
  assign rvalid1 = tag2_valid & tag2_port;

endmodule

// File: tb/tb_mcpu_ram_arbiter.sv
// Bench for mcpu_ram_arbiter: per-cycle vector table with expected grants, a RAM
// model behind the command port, and a read-return scoreboard keyed by cycle and port.
module tb_mcpu_ram_arbiter;

  localparam int W = 33;  // {due cycle[15:0], port, data[15:0]}

  logic        clk;
  logic        reset;
  logic        req0, we0, lock0, req1, we1, lock1;
  logic [7:0]  addr0, addr1;
  logic [15:0] wdata0, wdata1;
  logic        gnt0, gnt1, rvalid0, rvalid1;
  logic [15:0] rdata;
  logic        ram_we, ram_re;
  logic [7:0]  ram_addr;
  logic [15:0] ram_wdata, ram_rdata;

  mcpu_ram_arbiter #(.WORD_SIZE(16), .ADDR_WIDTH(8)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .we0(we0), .lock0(lock0), .addr0(addr0), .wdata0(wdata0),
    .gnt0(gnt0), .rvalid0(rvalid0),
    .req1(req1), .we1(we1), .lock1(lock1), .addr1(addr1), .wdata1(wdata1),
    .gnt1(gnt1), .rvalid1(rvalid1),
    .rdata(rdata),
    .ram_we(ram_we), .ram_re(ram_re), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM model: asynchronous read, write on the edge after ram_we
  logic [15:0] mem [256];
  logic [15:0] model_mem [256];
  assign ram_rdata = mem[ram_addr];
  always @(posedge clk) if (ram_we) mem[ram_addr] <= ram_wdata;

  int n_checks = 0;
  int n_err = 0;
  logic [W-1:0] exp_q[$];

  logic        exp_we = 1'b0, exp_re = 1'b0;
  logic [7:0]  exp_addr = 8'h00;
  logic [15:0] exp_wdata = 16'h0000;
  logic        tb_last = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  // scoreboard: read returns
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (rvalid0 === 1'b1 && rvalid1 === 1'b1) chk("rvalid_both", 32'd1, 32'd0);
    if (rvalid0 === 1'b1 || rvalid1 === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("rvalid_unexpected", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("rvalid_cycle", {16'h0, 16'(cyc)}, {16'h0, e[32:17]});
        chk("rvalid_port", {31'h0, rvalid1}, {31'h0, e[16]});
        chk("rdata", {16'h0, rdata}, {16'h0, e[15:0]});
      end
    end else if (exp_q.size() > 0 && exp_q[0][32:17] <= 16'(cyc)) begin
      e = exp_q.pop_front();
      chk("rvalid_missing", 32'd0, 32'd1);
    end
  end

  typedef struct {
    logic        rst;
    logic        req0, we0, lock0;
    logic [7:0]  addr0;
    logic [15:0] wdata0;
    logic        req1, we1, lock1;
    logic [7:0]  addr1;
    logic [15:0] wdata1;
    logic        g0, g1;
  } vec_t;

  function automatic vec_t mk(bit r0, bit w0, bit l0, int a0, int d0,
                              bit r1, bit w1, bit l1, int a1, int d1, bit g0, bit g1);
    vec_t v;
    v.rst = 1'b0;
    v.req0 = r0; v.we0 = w0; v.lock0 = l0; v.addr0 = 8'(a0); v.wdata0 = 16'(d0);
    v.req1 = r1; v.we1 = w1; v.lock1 = l1; v.addr1 = 8'(a1); v.wdata1 = 16'(d1);
    v.g0 = g0; v.g1 = g1;
    return v;
  endfunction

  // driver: one cycle per vector, expectations updated from the expected grant
  task automatic apply(input vec_t v, input int id);
    logic        sel1, swe;
    logic [7:0]  sa;
    logic [15:0] sd;
    reset = v.rst;
    req0 = v.req0; we0 = v.we0; lock0 = v.lock0; addr0 = v.addr0; wdata0 = v.wdata0;
    req1 = v.req1; we1 = v.we1; lock1 = v.lock1; addr1 = v.addr1; wdata1 = v.wdata1;
    @(negedge clk);
    chk($sformatf("v%0d ram_we", id), {31'h0, ram_we}, {31'h0, exp_we});
    chk($sformatf("v%0d ram_re", id), {31'h0, ram_re}, {31'h0, exp_re});
    chk($sformatf("v%0d ram_addr", id), {24'h0, ram_addr}, {24'h0, exp_addr});
    chk($sformatf("v%0d ram_wdata", id), {16'h0, ram_wdata}, {16'h0, exp_wdata});
    chk($sformatf("v%0d gnt0", id), {31'h0, gnt0}, {31'h0, v.g0});
    chk($sformatf("v%0d gnt1", id), {31'h0, gnt1}, {31'h0, v.g1});
    if (v.rst) begin
      exp_we = 1'b0; exp_re = 1'b0; exp_addr = 8'h00; exp_wdata = 16'h0000;
      tb_last = 1'b1;
      exp_q.delete();
    end else if (v.g0 || v.g1) begin
      sel1 = v.g1;
      swe  = sel1 ? v.we1 : v.we0;
      sa   = sel1 ? v.addr1 : v.addr0;
      sd   = sel1 ? v.wdata1 : v.wdata0;
      exp_we = swe; exp_re = !swe; exp_addr = sa; exp_wdata = sd;
      tb_last = sel1;
      if (swe) model_mem[sa] = sd;
      else exp_q.push_back({16'(cyc + 2), sel1, model_mem[sa]});
    end else begin
      exp_we = 1'b0; exp_re = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[$];
  vec_t v;
  vec_t idle;

  initial begin
    bit          p0, p1, eg0, eg1;
    logic        w0r, w1r;
    int          a0r, a1r, d0r, d1r;
    p0 = 0; p1 = 0; w0r = 0; w1r = 0; a0r = 0; a1r = 0; d0r = 0; d1r = 0;

    for (int i = 0; i < 256; i++) begin
      mem[i] = 16'h1000 + 16'(i);
      model_mem[i] = 16'h1000 + 16'(i);
    end
    idle = mk(0,0,0,0,0, 0,0,0,0,0, 0,0);

    reset = 1'b1;
    req0 = 0; we0 = 0; lock0 = 0; addr0 = 0; wdata0 = 0;
    req1 = 0; we1 = 0; lock1 = 0; addr1 = 0; wdata1 = 0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("reset rdata", {16'h0, rdata}, 32'h0);
    chk("reset rvalid0", {31'h0, rvalid0}, 32'h0);
    chk("reset rvalid1", {31'h0, rvalid1}, 32'h0);

    // single read on port 0
    tbl.push_back(mk(1,0,0,'h10,0, 0,0,0,0,0, 1,0));
    tbl.push_back(idle);
    tbl.push_back(idle);
    tbl.push_back(mk(0,0,0,0,0, 1,0,0,'h11,0, 0,1));
    // both ports streaming, unlocked: grants alternate starting with port 0
    tbl.push_back(mk(1,1,0,'h20,'h2000, 1,0,0,'h30,0, 1,0));
    tbl.push_back(mk(1,1,0,'h21,'h2001, 1,0,0,'h30,0, 0,1));
    tbl.push_back(mk(1,1,0,'h21,'h2001, 1,0,0,'h31,0, 1,0));
    tbl.push_back(mk(1,1,0,'h22,'h2002, 1,0,0,'h31,0, 0,1));
    tbl.push_back(mk(1,1,0,'h22,'h2002, 1,0,0,'h32,0, 1,0));
    tbl.push_back(mk(1,1,0,'h23,'h2003, 1,0,0,'h32,0, 0,1));
    tbl.push_back(mk(1,1,0,'h23,'h2003, 1,0,0,'h33,0, 1,0));
    tbl.push_back(mk(0,0,0,0,0,        1,0,0,'h33,0, 0,1));
    tbl.push_back(mk(1,1,0,'h24,'h2004, 0,0,0,0,0, 1,0));
    // port 1 locked burst while port 0 keeps requesting
    tbl.push_back(mk(1,0,0,'h40,0, 1,1,1,'h40,'hA0A0, 0,1));
    tbl.push_back(mk(1,0,0,'h40,0, 1,1,1,'h41,'hA0A1, 0,1));
    tbl.push_back(mk(1,0,0,'h40,0, 1,1,1,'h42,'hA0A2, 0,1));
    tbl.push_back(mk(1,0,0,'h40,0, 1,1,0,'h43,'hA0A3, 0,1));
    tbl.push_back(mk(1,0,0,'h40,0, 1,0,0,'h43,0, 1,0));
    tbl.push_back(mk(0,0,0,0,0,    1,0,0,'h43,0, 0,1));
    // port 0 locked, drops req for one cycle
    tbl.push_back(mk(1,1,1,'h50,'h5000, 1,0,0,'h51,0, 1,0));
    tbl.push_back(mk(1,1,1,'h51,'h5001, 1,0,0,'h51,0, 1,0));
    tbl.push_back(mk(0,0,0,0,0,         1,0,0,'h51,0, 0,1));
    tbl.push_back(mk(1,1,0,'h52,'h5002, 1,0,0,'h52,0, 1,0));
    tbl.push_back(mk(0,0,0,0,0,         1,0,0,'h52,0, 0,1));
    // write then read, and read then write, same address
    tbl.push_back(mk(1,1,0,'h08,'h5555, 0,0,0,0,0, 1,0));
    tbl.push_back(mk(0,0,0,0,0,         1,0,0,'h08,0, 0,1));
    tbl.push_back(idle);
    tbl.push_back(mk(0,0,0,0,0,         1,0,0,'h08,0, 0,1));
    tbl.push_back(mk(1,1,0,'h08,'hBEEF, 0,0,0,0,0, 1,0));
    tbl.push_back(idle);
    // lock from the conflict winner is honoured
    tbl.push_back(mk(1,0,0,'h10,0, 1,1,1,'h60,'h6000, 0,1));
    tbl.push_back(mk(1,0,0,'h10,0, 1,1,0,'h61,'h6001, 0,1));
    tbl.push_back(mk(1,0,0,'h10,0, 0,0,0,0,0, 1,0));
    tbl.push_back(idle);

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

    // random unlocked traffic with hold-until-grant requesters
    for (int i = 0; i < 24; i++) begin
      if (!p0 && $urandom_range(0, 3) != 0) begin
        p0 = 1; w0r = 1'($urandom_range(0, 1));
        a0r = $urandom_range(8'h70, 8'h77); d0r = $urandom_range(0, 65535);
      end
      if (!p1 && $urandom_range(0, 3) != 0) begin
        p1 = 1; w1r = 1'($urandom_range(0, 1));
        a1r = $urandom_range(8'h70, 8'h77); d1r = $urandom_range(0, 65535);
      end
      eg0 = p0 && (!p1 || tb_last);
      eg1 = p1 && (!p0 || !tb_last);
      v = mk(p0, w0r, 0, a0r, d0r, p1, w1r, 0, a1r, d1r, eg0, eg1);
      apply(v, 100 + i);
      if (eg0) p0 = 0;
      if (eg1) p1 = 0;
    end

    // reset while a port 1 read is in flight
    apply(idle, 200);
    apply(idle, 201);
    apply(mk(0,0,0,0,0, 1,0,0,'h11,0, 0,1), 202);
    v = mk(1,0,0,'h12,0, 1,0,0,'h13,0, 0,0);
    v.rst = 1'b1;
    apply(v, 203);
    chk("midreset rdata", {16'h0, rdata}, 32'h0);
    chk("midreset rvalid1", {31'h0, rvalid1}, 32'h0);
    apply(idle, 204);
    apply(mk(1,0,0,'h12,0, 1,0,0,'h13,0, 1,0), 205);
    apply(mk(0,0,0,0,0,    1,0,0,'h13,0, 0,1), 206);
    repeat (4) apply(idle, 207);

    chk("scoreboard drained", exp_q.size(), 32'd0);
    for (int a = 0; a < 256; a++)
      chk($sformatf("mem[%0h]", a), {16'h0, mem[a]}, {16'h0, model_mem[a]});

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
